// File: rtl/in_pkt_buffer.sv
// Store-and-forward ingress packet buffer: captures a no-backpressure word stream,
// drops whole packets on shortage, replays committed packets over valid/ready.
// Optional macro IN_PKT_BUFFER_DROP_CNT_EN enables the drop counter.
//
// Write FSM
//   state   | meaning
//   W_IDLE  | waiting for a header beat, space/descriptor check
//   W_STORE | writing payload beats of an accepted packet
//   W_DROP  | discarding payload beats of a rejected packet
// Read FSM
//   state   | meaning
//   R_IDLE  | no committed packet
//   R_FETCH | header RAM read, descriptor outputs loaded
//   R_SEND  | presenting words on the output interface
module in_pkt_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int WIDTH_SEL      = 4,
    parameter int WIDTH_LENGTH   = 10,
    parameter int WIDTH_PRIORITY = 3,
    parameter int BUF_DEPTH      = 512,
    parameter int DESC_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_vld,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic [WIDTH_SEL-1:0]          in_rx,
    input  logic [WIDTH_SEL-1:0]          in_tx,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [WIDTH_SEL-1:0]          out_dest,
    output logic [WIDTH_SEL-1:0]          out_src,
    output logic [WIDTH_PRIORITY-1:0]     out_priority,
    output logic [WIDTH_LENGTH-1:0]       out_length,
    output logic [$clog2(DESC_DEPTH):0]   pkt_cnt,
    output logic [15:0]                   drop_cnt
);
    localparam int AW     = $clog2(BUF_DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int DAW    = $clog2(DESC_DEPTH);
    localparam int CW     = DAW + 1;
    localparam int HL_LSB = WIDTH_PRIORITY + 16;
    localparam logic [31:0] DEPTH32 = BUF_DEPTH;

    typedef struct packed {
        logic [WIDTH_SEL-1:0]      dest;
        logic [WIDTH_SEL-1:0]      src;
        logic [WIDTH_PRIORITY-1:0] prio;
        logic [WIDTH_LENGTH-1:0]   len;
        logic [AW-1:0]             start;
    } desc_t;

    typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    desc_t                 desc_mem [DESC_DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    wr_state_t wr_state, wr_state_nx;
    rd_state_t rd_state, rd_state_nx;

    logic [PTR_W-1:0]        wr_ptr, wr_ptr_nx, wr_addr, wr_addr_nx, rd_ptr;
    logic [WIDTH_LENGTH-1:0] rem, rem_nx;
    desc_t                   cur_desc, cur_desc_nx, hdr_desc, push_desc, head;
    logic [CW-1:0]           desc_cnt;
    logic [DAW-1:0]          desc_wr_idx, desc_rd_idx;
    logic                    push, pop, drop_evt, ram_we, ram_re, load_desc;
    logic [AW-1:0]           ram_waddr, ram_raddr, rd_addr, rd_addr_nx;
    logic [WIDTH_LENGTH-1:0] word_idx, word_idx_nx, hdr_len;
    logic [PTR_W-1:0]        used;
    logic [31:0]             free32, need32;
    logic                    desc_full, fits;

    assign hdr_len   = in_data[HL_LSB +: WIDTH_LENGTH];
    assign hdr_desc  = '{dest: in_rx, src: in_tx, prio: in_data[WIDTH_PRIORITY-1:0],
                         len: hdr_len, start: wr_ptr[AW-1:0]};
    assign head      = desc_mem[desc_rd_idx];
    // Space is judged against the committed read pointer only, so a word freed this cycle is not yet counted.
    assign used      = wr_ptr - rd_ptr;
    assign free32    = DEPTH32 - 32'(used);
    assign need32    = 32'(hdr_len) + 32'd1;
    assign desc_full = (desc_cnt == CW'(DESC_DEPTH));
    assign fits      = (need32 <= free32) && !desc_full;

    always_comb begin
        wr_state_nx = wr_state;
        wr_ptr_nx   = wr_ptr;
        wr_addr_nx  = wr_addr;
        rem_nx      = rem;
        cur_desc_nx = cur_desc;
        push_desc   = cur_desc;
        ram_we      = 1'b0;
        ram_waddr   = wr_addr[AW-1:0];
        push        = 1'b0;
        drop_evt    = 1'b0;
        case (wr_state)
            W_IDLE: if (in_vld) begin
                rem_nx = hdr_len;
                if (fits) begin
                    ram_we      = 1'b1;
                    ram_waddr   = wr_ptr[AW-1:0];
                    wr_addr_nx  = wr_ptr + PTR_W'(1);
                    cur_desc_nx = hdr_desc;
                    if (hdr_len == '0) begin
                        push      = 1'b1;
                        push_desc = hdr_desc;
                        wr_ptr_nx = wr_ptr + PTR_W'(1);
                    end else begin
                        wr_state_nx = W_STORE;
                    end
                end else if (hdr_len == '0) begin
                    drop_evt = 1'b1;
                end else begin
                    wr_state_nx = W_DROP;
                end
            end
            W_STORE: if (in_vld) begin
                ram_we     = 1'b1;
                wr_addr_nx = wr_addr + PTR_W'(1);
                rem_nx     = rem - WIDTH_LENGTH'(1);
                if (rem == WIDTH_LENGTH'(1)) begin
                    push        = 1'b1;
                    wr_ptr_nx   = wr_addr + PTR_W'(1);
                    wr_state_nx = W_IDLE;
                end
            end
            W_DROP: if (in_vld) begin
                rem_nx = rem - WIDTH_LENGTH'(1);
                if (rem == WIDTH_LENGTH'(1)) begin
                    drop_evt    = 1'b1;
                    wr_state_nx = W_IDLE;
                end
            end
            default: wr_state_nx = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_nx = rd_state;
        rd_addr_nx  = rd_addr;
        word_idx_nx = word_idx;
        ram_re      = 1'b0;
        ram_raddr   = rd_addr;
        load_desc   = 1'b0;
        pop         = 1'b0;
        case (rd_state)
            R_IDLE: if (desc_cnt != '0) rd_state_nx = R_FETCH;
            R_FETCH: begin
                ram_re      = 1'b1;
                ram_raddr   = head.start;
                rd_addr_nx  = head.start + AW'(1);
                word_idx_nx = '0;
                load_desc   = 1'b1;
                rd_state_nx = R_SEND;
            end
            R_SEND: if (out_ready) begin
                if (word_idx == out_length) begin
                    pop         = 1'b1;
                    rd_state_nx = (desc_cnt > CW'(1) || push) ? R_FETCH : R_IDLE;
                end else begin
                    ram_re      = 1'b1;
                    rd_addr_nx  = rd_addr + AW'(1);
                    word_idx_nx = word_idx + WIDTH_LENGTH'(1);
                end
            end
            default: rd_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= in_data;
        if (ram_re) ram_q <= mem[ram_raddr];
        if (push)   desc_mem[desc_wr_idx] <= push_desc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state     <= W_IDLE;
            rd_state     <= R_IDLE;
            wr_ptr       <= '0;
            wr_addr      <= '0;
            rd_ptr       <= '0;
            rem          <= '0;
            cur_desc     <= '0;
            desc_cnt     <= '0;
            desc_wr_idx  <= '0;
            desc_rd_idx  <= '0;
            rd_addr      <= '0;
            word_idx     <= '0;
            out_dest     <= '0;
            out_src      <= '0;
            out_priority <= '0;
            out_length   <= '0;
        end else begin
            wr_state <= wr_state_nx;
            rd_state <= rd_state_nx;
            wr_ptr   <= wr_ptr_nx;
            wr_addr  <= wr_addr_nx;
            rem      <= rem_nx;
            cur_desc <= cur_desc_nx;
            rd_addr  <= rd_addr_nx;
            word_idx <= word_idx_nx;
            desc_cnt <= desc_cnt + CW'(push) - CW'(pop);
            if (push) desc_wr_idx <= desc_wr_idx + DAW'(1);
            if (pop) begin
                desc_rd_idx <= desc_rd_idx + DAW'(1);
                rd_ptr      <= rd_ptr + PTR_W'(32'(out_length) + 32'd1);
            end
            if (load_desc) begin
                out_dest     <= head.dest;
                out_src      <= head.src;
                out_priority <= head.prio;
                out_length   <= head.len;
            end
        end
    end

    assign out_valid = (rd_state == R_SEND);
    assign out_sop   = out_valid && (word_idx == '0);
    assign out_eop   = out_valid && (word_idx == out_length);
    assign out_data  = out_valid ? ram_q : '0;
    assign pkt_cnt   = desc_cnt;

`ifdef IN_PKT_BUFFER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            drop_cnt_q <= '0;
        else if (drop_evt && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end
    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = drop_evt;
    assign drop_cnt    = '0;
`endif

    // CRC and upper header bits are carried through RAM but not decoded here.
    logic unused_hdr;
    assign unused_hdr = ^in_data;

endmodule
